apa102_frame_sequencer: RTL and testbench

APA102_FRAME_SEQUENCER -- requirements
Module: apa102_frame_sequencer

---
 rtl/apa102_pkg.sv | 45 ++++
 rtl/apa102_frame_sequencer_if.sv | 48 ++++
 rtl/apa102_frame_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_apa102_frame_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apa102_pkg.sv
// Shared APA102 definitions: driver command codes, frame sequencer states, pixel colour.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents:
//   apa_cmd_t   - command word presented to the APA102 driver alongside its strobe
//   seq_state_t - frame sequencer state encoding
//   rgb_t       - one pixel colour, red in the top byte
package apa102_pkg;

  // Command codes understood by the APA102 serial driver. NONE is what the
  // bus carries whenever no strobe is being issued.
  typedef enum logic [1:0] {
    APA_NONE  = 2'b00,
    APA_SOF   = 2'b01,
    APA_PIXEL = 2'b10,
    APA_EOF   = 2'b11
  } apa_cmd_t;

  // Frame sequencer states.
  //   IDLE     - waiting for frame_start
  //   SOF      - issue the start-of-frame command once the driver is free
  //   PIX_REQ  - one-cycle request to the pixel source
  //   PIX_WAIT - wait for the pixel source to answer
  //   PIX_SEND - issue the PIXEL command once the driver is free
  //   EOF      - issue the end-of-frame command once the driver is free
  //   CMD_HOLD - cycle(s) following every strobe; decides what comes next
  //   DONE     - one-cycle frame completion
  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_SOF,
    SEQ_PIX_REQ,
    SEQ_PIX_WAIT,
    SEQ_PIX_SEND,
    SEQ_EOF,
    SEQ_CMD_HOLD,
    SEQ_DONE
  } seq_state_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

endpackage

// File: rtl/apa102_frame_sequencer_if.sv
// Pixel-source and APA102-driver signal bundle seen by the frame sequencer.
// Latency: n/a (wiring only).
// Backpressure: driver stalls commands via apa_busy; source paces pixels via px_valid.
// Ports (master = sequencer side):
//   px_req/px_index                 -> pixel source request and pixel index
//   px_valid/px_red/px_green/px_blue <- pixel source response
//   apa_cmd/apa_strobe               -> driver command and its one-cycle strobe
//   apa_red/apa_green/apa_blue       -> pixel colour for the PIXEL command
//   apa_busy                         <- driver busy
interface apa102_frame_sequencer_if
  import apa102_pkg::*;
#(
  parameter int CW = 16
) ();

  // Pixel source side
  logic          px_req;
  logic [CW-1:0] px_index;
  logic          px_valid;
  logic [7:0]    px_red;
  logic [7:0]    px_green;
  logic [7:0]    px_blue;

  // APA102 driver side
  apa_cmd_t      apa_cmd;
  logic          apa_strobe;
  logic          apa_busy;
  logic [7:0]    apa_red;
  logic [7:0]    apa_green;
  logic [7:0]    apa_blue;

  // Sequencer view
  modport master (
    output px_req, px_index,
    input  px_valid, px_red, px_green, px_blue,
    output apa_cmd, apa_strobe, apa_red, apa_green, apa_blue,
    input  apa_busy
  );

  // Pixel source / driver view
  modport slave (
    input  px_req, px_index,
    output px_valid, px_red, px_green, px_blue,
    input  apa_cmd, apa_strobe, apa_red, apa_green, apa_blue,
    output apa_busy
  );

endinterface

// File: rtl/apa102_frame_sequencer.sv
// Sequences one APA102 frame: SOF, one fetched-and-sent PIXEL per LED, EOF, then frame_done.
// Latency: strobes are combinational on apa_busy low in SOF/PIX_SEND/EOF; >= 2 cycles between strobes.
// Backpressure: waits on apa_busy before every strobe and on px_valid for every pixel; drops busy-time frame_start.
// Ports:
//   clk, rst_n            - system clock, asynchronous active-low reset
//   frame_start           - one-cycle frame request (accepted only in IDLE)
//   num_pixels            - pixel count, sampled on acceptance, clamped to MAX_PIXELS
//   frame_busy            - high from acceptance until the DONE cycle inclusive
//   frame_done            - one-cycle pulse at frame completion
//   overrun               - one-cycle pulse the cycle after a dropped frame_start
//   bus                   - pixel source and APA102 driver signals (master modport)
module apa102_frame_sequencer
  import apa102_pkg::*;
#(
  parameter int CW         = 16,
  parameter int MAX_PIXELS = 300
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_start,
  input  logic [CW-1:0]                   num_pixels,
  output logic                            frame_busy,
  output logic                            frame_done,
  output logic                            overrun,
  apa102_frame_sequencer_if.master        bus
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_PIXELS);

  seq_state_t    state_q;
  seq_state_t    state_d;

  logic [CW-1:0] count_q;      // clamped pixel count of the frame in flight
  logic [CW-1:0] index_q;      // next pixel to fetch; never exceeds count_q
  apa_cmd_t      last_cmd_q;   // command issued by the most recent strobe
  logic          hold_seen_q;  // CMD_HOLD has already spent its first cycle
  rgb_t          colour_q;     // colour presented to the driver
  logic          overrun_q;

  logic          strobe;
  apa_cmd_t      cmd;
  logic [CW-1:0] count_clamped;

  assign count_clamped = (num_pixels > MAX_COUNT) ? MAX_COUNT : num_pixels;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // Next state and strobe generation
  // ------------------------------------------------------------------
  // Strobes are issued straight from the strobe states whenever the driver
  // is free, and every strobe is followed by at least one CMD_HOLD cycle in
  // which apa_busy is not looked at. That gap covers the driver's one-cycle
  // delay in raising busy after it registers the strobe, and it is what
  // guarantees the minimum two-cycle strobe spacing.
  always_comb begin
    state_d = state_q;
    strobe  = 1'b0;
    cmd     = APA_NONE;

    case (state_q)
      SEQ_IDLE: begin
        if (frame_start) begin
          state_d = SEQ_SOF;
        end
      end

      SEQ_SOF: begin
        if (!bus.apa_busy) begin
          strobe  = 1'b1;
          cmd     = APA_SOF;
          state_d = SEQ_CMD_HOLD;
        end
      end

      SEQ_PIX_REQ: begin
        state_d = SEQ_PIX_WAIT;
      end

      SEQ_PIX_WAIT: begin
        if (bus.px_valid) begin
          state_d = SEQ_PIX_SEND;
        end
      end

      SEQ_PIX_SEND: begin
        if (!bus.apa_busy) begin
          strobe  = 1'b1;
          cmd     = APA_PIXEL;
          state_d = SEQ_CMD_HOLD;
        end
      end

      SEQ_EOF: begin
        if (!bus.apa_busy) begin
          strobe  = 1'b1;
          cmd     = APA_EOF;
          state_d = SEQ_CMD_HOLD;
        end
      end

      SEQ_CMD_HOLD: begin
        case (last_cmd_q)
          APA_SOF: begin
            state_d = (count_q == '0) ? SEQ_EOF : SEQ_PIX_REQ;
          end
          APA_PIXEL: begin
            // index_q was already advanced in the PIXEL strobe cycle.
            state_d = (index_q < count_q) ? SEQ_PIX_REQ : SEQ_EOF;
          end
          default: begin
            // After EOF the frame is only complete once the driver has
            // finished shifting it out; the first hold cycle is skipped
            // because busy may not have risen yet.
            if (hold_seen_q && !bus.apa_busy) begin
              state_d = SEQ_DONE;
            end
          end
        endcase
      end

      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      index_q     <= '0;
      last_cmd_q  <= APA_NONE;
      hold_seen_q <= 1'b0;
      colour_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if ((state_q == SEQ_IDLE) && frame_start) begin
        count_q <= count_clamped;
        index_q <= '0;
      end

      if (strobe) begin
        last_cmd_q  <= cmd;
        hold_seen_q <= 1'b0;
        // The clamp bounds index_q by MAX_PIXELS, so this cannot wrap.
        if (cmd == APA_PIXEL) begin
          index_q <= index_q + CW'(1);
        end
      end else if (state_q == SEQ_CMD_HOLD) begin
        hold_seen_q <= 1'b1;
      end

      // The source's colour is only meaningful while we are waiting for it;
      // px_valid anywhere else is ignored so stray responses cannot corrupt
      // the colour held for the driver.
      if ((state_q == SEQ_PIX_WAIT) && bus.px_valid) begin
        colour_q.red   <= bus.px_red;
        colour_q.green <= bus.px_green;
        colour_q.blue  <= bus.px_blue;
      end

      overrun_q <= frame_start && (state_q != SEQ_IDLE);
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.apa_strobe = strobe;
  assign bus.apa_cmd    = cmd;
  assign bus.px_req     = (state_q == SEQ_PIX_REQ);
  assign bus.px_index   = index_q;
  assign bus.apa_red    = colour_q.red;
  assign bus.apa_green  = colour_q.green;
  assign bus.apa_blue   = colour_q.blue;

  assign frame_busy     = (state_q != SEQ_IDLE);
  assign frame_done     = (state_q == SEQ_DONE);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_apa102_frame_sequencer.sv
// Self-checking bench for apa102_frame_sequencer with driver and pixel-source models.
// Latency: n/a.
// Backpressure: driver model holds apa_busy for a configurable time after each strobe.
`timescale 1ns/1ps
module tb_apa102_frame_sequencer;
  import apa102_pkg::*;

  localparam int CW         = 16;
  localparam int MAX_PIXELS = 300;
  localparam int BUDGET     = 20000;

  typedef struct {
    apa_cmd_t    cmd;
    logic [23:0] col;
  } exp_t;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          frame_start = 1'b0;
  logic [CW-1:0] num_pixels  = '0;
  logic          frame_busy;
  logic          frame_done;
  logic          overrun;

  apa102_frame_sequencer_if #(.CW(CW)) bus ();

  apa102_frame_sequencer #(
    .CW         (CW),
    .MAX_PIXELS (MAX_PIXELS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .num_pixels  (num_pixels),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard and statistics
  int   n_checks    = 0;
  int   n_errors    = 0;
  exp_t exp_q[$];
  int   idx_q[$];
  exp_t e;
  int   cyc         = 0;
  int   last_strobe = -100;
  int   done_cnt    = 0;
  int   ovr_cnt     = 0;
  int   req_cnt     = 0;
  int   pix_strobes = 0;
  int   last_idx    = -1;

  // Model configuration and state
  int            busy_len = 5;
  int            px_dly   = 2;
  bit            noise    = 1'b0;
  logic [7:0]    salt     = 8'h00;
  int            busy_rem = 0;
  int            pend     = 0;
  logic [CW-1:0] req_idx  = '0;
  logic          nxt_busy  = 1'b0;
  logic          nxt_valid = 1'b0;
  logic [23:0]   nxt_col   = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] colour_of(input int i, input logic [7:0] s);
    logic [7:0] r, g, b;
    r = 8'(i * 3) + s;
    g = 8'(i) ^ (s ^ 8'h5A);
    b = 8'(255 - i);
    return {r, g, b};
  endfunction

  // Monitor + driver/source models: sample at negedge, apply at posedge+1.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      idx_q.delete();
      busy_rem    = 0;
      pend        = 0;
      last_strobe = -100;
      nxt_busy    = 1'b0;
      nxt_valid   = 1'b0;
    end else begin
      if (bus.apa_strobe) begin
        check_eq("strobe_while_busy", 32'(bus.apa_busy), 32'd0);
        check_eq("strobe_gap_ge2", 32'((cyc - last_strobe) >= 2), 32'd1);
        last_strobe = cyc;
        check_eq("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("strobe_cmd", 32'(bus.apa_cmd), 32'(e.cmd));
          if (e.cmd == APA_PIXEL) begin
            check_eq("pixel_colour", 32'({bus.apa_red, bus.apa_green, bus.apa_blue}), 32'(e.col));
            pix_strobes++;
          end
        end
      end else begin
        check_eq("cmd_none_off_strobe", 32'(bus.apa_cmd), 32'(APA_NONE));
      end

      if (bus.px_req) begin
        req_cnt++;
        check_eq("px_req_expected", 32'(idx_q.size() > 0), 32'd1);
        if (idx_q.size() > 0) begin
          check_eq("px_index", 32'(bus.px_index), 32'(idx_q.pop_front()));
        end
        last_idx = int'(bus.px_index);
      end

      if (frame_done) done_cnt++;
      if (overrun)    ovr_cnt++;

      // Driver: busy for busy_len cycles starting the cycle after a strobe.
      if (bus.apa_strobe) busy_rem = busy_len;
      else if (busy_rem > 0) busy_rem--;
      nxt_busy = (busy_rem > 0);

      // Source: answer px_dly cycles after a request; optional stray valids.
      if (pend > 0) pend--;
      if (bus.px_req) begin
        pend    = px_dly;
        req_idx = bus.px_index;
      end
      if (pend == 1) begin
        nxt_valid = 1'b1;
        nxt_col   = colour_of(int'(req_idx), salt);
      end else begin
        nxt_valid = (pend == 0) && noise && ($urandom_range(0, 2) == 0);
        nxt_col   = 24'($urandom);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.apa_busy = nxt_busy;
    bus.px_valid = nxt_valid;
    {bus.px_red, bus.px_green, bus.px_blue} = nxt_col;
  end

  task automatic push_expect(input int n);
    int eff;
    eff = (n > MAX_PIXELS) ? MAX_PIXELS : n;
    exp_q.push_back('{APA_SOF, 24'h0});
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back('{APA_PIXEL, colour_of(i, salt)});
      idx_q.push_back(i);
    end
    exp_q.push_back('{APA_EOF, 24'h0});
  endtask

  task automatic start_pulse(input int n);
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    num_pixels  = CW'(n);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_strobe",     32'(bus.apa_strobe), 32'd0);
    check_eq("rst_cmd",        32'(bus.apa_cmd), 32'(APA_NONE));
    check_eq("rst_px_req",     32'(bus.px_req), 32'd0);
    check_eq("rst_px_index",   32'(bus.px_index), 32'd0);
    check_eq("rst_frame_busy", 32'(frame_busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_overrun",    32'(overrun), 32'd0);
    check_eq("rst_colour",     32'({bus.apa_red, bus.apa_green, bus.apa_blue}), 32'd0);
  endtask

  task automatic run_frame(input int n, input int blen, input int dly, input bit nz, input bit done_start);
    int eff, d0, r0, p0, waited;
    eff      = (n > MAX_PIXELS) ? MAX_PIXELS : n;
    busy_len = blen;
    px_dly   = dly;
    noise    = nz;
    salt     = 8'($urandom);
    push_expect(n);
    d0 = done_cnt;
    r0 = req_cnt;
    p0 = pix_strobes;
    start_pulse(n);
    @(negedge clk);
    check_eq("frame_busy_set", 32'(frame_busy), 32'd1);
    waited = 0;
    while (frame_done !== 1'b1 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check_eq("frame_done_in_budget", 32'(waited < BUDGET), 32'd1);
    if (done_start) begin
      #1;
      frame_start = 1'b1;
      num_pixels  = CW'(3);
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      @(negedge clk);
      check_eq("done_cycle_overrun", 32'(overrun), 32'd1);
    end
    repeat (3) @(negedge clk);
    check_eq("frame_busy_clear", 32'(frame_busy), 32'd0);
    check_eq("frame_done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("strobes_left",     32'(exp_q.size()), 32'd0);
    check_eq("px_req_count",     32'(req_cnt - r0), 32'(eff));
    check_eq("pixel_strobes",    32'(pix_strobes - p0), 32'(eff));
  endtask

  initial begin
    int o0, d0, waited;
    bus.apa_busy = 1'b0;
    bus.px_valid = 1'b0;
    bus.px_red   = '0;
    bus.px_green = '0;
    bus.px_blue  = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three pixels, slow driver, source answers after 2 cycles.
    run_frame(3, 5, 2, 1'b0, 1'b0);
    check_eq("last_index_n3", 32'(last_idx), 32'd2);

    // Empty frame: SOF then EOF only.
    run_frame(0, 5, 2, 1'b0, 1'b0);

    // Over-long frame is clamped; stray px_valid injected between fetches.
    run_frame(500, 1, 1, 1'b1, 1'b0);
    check_eq("last_index_clamp", 32'(last_idx), 32'(MAX_PIXELS - 1));

    // frame_start mid-frame is dropped and reported once.
    o0 = ovr_cnt;
    fork
      run_frame(4, 5, 2, 1'b0, 1'b0);
      begin
        repeat (15) @(posedge clk);
        #1;
        frame_start = 1'b1;
        num_pixels  = CW'(9);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        check_eq("overrun_pulse", 32'(overrun), 32'd1);
        @(negedge clk);
        check_eq("overrun_single", 32'(overrun), 32'd0);
      end
    join
    check_eq("overrun_count", 32'(ovr_cnt - o0), 32'd1);

    // Driver never busy: spacing floor and colour; frame_start in DONE is dropped.
    run_frame(6, 0, 1, 1'b1, 1'b1);
    run_frame(5, 0, 3, 1'b0, 1'b0);

    // Reset in the middle of the pixel phase.
    busy_len = 2;
    px_dly   = 1;
    noise    = 1'b0;
    salt     = 8'($urandom);
    d0       = done_cnt;
    push_expect(20);
    start_pulse(20);
    waited = 0;
    while (!(bus.px_req === 1'b1 && bus.px_index == CW'(10)) && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check_eq("reached_index10", 32'(waited < BUDGET), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    check_eq("idle_after_reset", 32'(frame_busy), 32'd0);

    run_frame(2, 3, 2, 1'b0, 1'b0);
    check_eq("last_index_post_reset", 32'(last_idx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
